// File: rtl/jam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jam_pkg
// Brief    : Shared types and constants for the 8x8 assignment sequencer.
// Revision : 1.0
// ============================================================================
package jam_pkg;

    localparam int N_WORK   = 8;
    localparam int NUM_PERM = 40320;

    typedef logic [2:0] job_t;
    typedef job_t [N_WORK-1:0] perm_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam perm_t C_IDENTITY = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

endpackage
`default_nettype wire

// File: rtl/jam_next_perm.sv
`default_nettype none
// ============================================================================
// Module   : jam_next_perm
// Brief    : Combinational lexicographic successor of an 8-element permutation.
// Revision : 1.0
// ============================================================================
module jam_next_perm
    import jam_pkg::*;
(
    input  perm_t i_perm,
    output perm_t o_next,
    output logic  o_last
);

    logic [2:0] w_p;
    logic [2:0] w_q;
    logic       w_found;
    perm_t      w_swap;

    always_comb begin
        w_p     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_WORK - 1; i++) begin
            if (i_perm[i] < i_perm[i+1]) begin
                w_p     = 3'(i);
                w_found = 1'b1;
            end
        end

        w_q = '0;
        for (int j = 0; j < N_WORK; j++) begin
            if ((j > int'(w_p)) && (i_perm[j] > i_perm[w_p])) begin
                w_q = 3'(j);
            end
        end

        w_swap      = i_perm;
        w_swap[w_p] = i_perm[w_q];
        w_swap[w_q] = i_perm[w_p];

        // Tail after the pivot is descending; reversing it gives the smallest suffix.
        o_next = w_swap;
        for (int k = 0; k < N_WORK; k++) begin
            if (k > int'(w_p)) begin
                o_next[k] = w_swap[3'(int'(w_p) + N_WORK - k)];
            end
        end

        o_last = ~w_found;
    end

endmodule
`default_nettype wire

// File: rtl/jam_sched.sv
`default_nettype none
// ============================================================================
// Module   : jam_sched
// Brief    : Loads the cost ROM, streams all permutations, reduces min cost.
// Revision : 1.0
// ============================================================================
module jam_sched
    import jam_pkg::*;
#(
    parameter int COST_W = 7,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [COST_W-1:0] Cost,
    output logic              tbl_we,
    output logic [2:0]        tbl_w,
    output logic [2:0]        tbl_j,
    output logic [COST_W-1:0] tbl_data,
    output logic              perm_valid,
    input  logic              perm_ready,
    output logic [23:0]       perm,
    input  logic              res_valid,
    input  logic [SUM_W-1:0]  res_cost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic [SUM_W-1:0]  MinCost,
    output logic              Valid
);

    localparam logic [15:0] C_LAST_IDX = 16'(NUM_PERM - 1);
    localparam logic [15:0] C_ALL      = 16'(NUM_PERM);

    sched_state_t     r_state;
    logic [6:0]       r_ld_idx;
    logic             r_we;
    logic [5:0]       r_wr_idx;
    logic             r_pv;
    perm_t            r_perm;
    logic [15:0]      r_issue;
    logic [15:0]      r_res_cnt;
    logic [SUM_W-1:0] r_min;
    logic [CNT_W-1:0] r_cnt;

    perm_t w_next;
    logic  w_last;
    logic  w_accept;
    logic  w_final_acc;
    logic  w_reduce;
    logic  w_res_done;

    jam_next_perm u_next (
        .i_perm (r_perm),
        .o_next (w_next),
        .o_last (w_last)
    );

    assign w_accept    = (r_state == RUN) && r_pv && perm_ready;
    assign w_final_acc = w_accept && w_last && (r_issue == C_LAST_IDX);
    assign w_reduce    = res_valid && ((r_state == RUN) || (r_state == DRAIN));
    assign w_res_done  = (r_res_cnt == C_ALL) || (w_reduce && (r_res_cnt == C_LAST_IDX));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= LOAD;
            r_ld_idx  <= '0;
            r_we      <= 1'b0;
            r_wr_idx  <= '0;
            r_pv      <= 1'b0;
            r_perm    <= C_IDENTITY;
            r_issue   <= '0;
            r_res_cnt <= '0;
            r_min     <= '1;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    // ROM data lags the address by one cycle, so the write trails the index.
                    if (!r_ld_idx[6]) begin
                        r_ld_idx <= r_ld_idx + 7'd1;
                        r_we     <= 1'b1;
                        r_wr_idx <= r_ld_idx[5:0];
                    end else begin
                        r_we    <= 1'b0;
                        r_pv    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_perm  <= w_next;
                        r_issue <= r_issue + 16'd1;
                    end
                    if (w_final_acc) begin
                        r_pv    <= 1'b0;
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_res_done) begin
                        r_state <= DONE;
                    end
                end
                default: begin
                end
            endcase

            if (w_reduce) begin
                r_res_cnt <= r_res_cnt + 16'd1;
                if (res_cost < r_min) begin
                    r_min <= res_cost;
                    r_cnt <= CNT_W'(1);
                end else if ((res_cost == r_min) && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign W          = r_ld_idx[5:3];
    assign J          = r_ld_idx[2:0];
    assign tbl_we     = r_we;
    assign tbl_w      = r_wr_idx[5:3];
    assign tbl_j      = r_wr_idx[2:0];
    assign tbl_data   = r_we ? Cost : '0;
    assign perm_valid = r_pv;
    assign perm       = r_perm;
    assign MinCost    = r_min;
    assign MatchCount = r_cnt;
    assign Valid      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_jam_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_sched
// Brief    : Directed + randomized bench for jam_sched with ROM/evaluator models.
// Revision : 1.0
// ============================================================================
module tb_jam_sched;

    localparam int COST_W = 7;
    localparam int SUM_W  = 10;
    localparam int CNT_W  = 4;
    localparam int NPERM  = 40320;

    logic              CLK        = 1'b0;
    logic              RST        = 1'b1;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [COST_W-1:0] Cost       = '0;
    logic              tbl_we;
    logic [2:0]        tbl_w;
    logic [2:0]        tbl_j;
    logic [COST_W-1:0] tbl_data;
    logic              perm_valid;
    logic              perm_ready = 1'b0;
    logic [23:0]       perm;
    logic              res_valid  = 1'b0;
    logic [SUM_W-1:0]  res_cost   = '0;
    logic [CNT_W-1:0]  MatchCount;
    logic [SUM_W-1:0]  MinCost;
    logic              Valid;

    jam_sched #(.COST_W(COST_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .tbl_we     (tbl_we),
        .tbl_w      (tbl_w),
        .tbl_j      (tbl_j),
        .tbl_data   (tbl_data),
        .perm_valid (perm_valid),
        .perm_ready (perm_ready),
        .perm       (perm),
        .res_valid  (res_valid),
        .res_cost   (res_cost),
        .MatchCount (MatchCount),
        .MinCost    (MinCost),
        .Valid      (Valid)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         rom    [64];
    int         ev_tbl [64];
    int         res_q  [$];
    int         n_acc, n_res, exp_min, exp_cnt, load_k, load_bad, seq_bad;
    longint     prev_key;
    bit         have_prev;
    int         ready_mode, pop_mode;
    bit         noise_en;
    logic [5:0] rom_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pk(input logic [2:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // Worker 0 is the most significant digit of the ordering key.
    function automatic longint lex_key(input logic [23:0] p);
        longint k = 0;
        for (int i = 0; i < 8; i++) k = k * 8 + longint'(p[3*i +: 3]);
        return k;
    endfunction

    function automatic bit is_perm(input logic [23:0] p);
        logic [7:0] seen = '0;
        for (int i = 0; i < 8; i++) seen[p[3*i +: 3]] = 1'b1;
        return seen == 8'hFF;
    endfunction

    function automatic int perm_cost(input logic [23:0] p);
        int s = 0;
        for (int i = 0; i < 8; i++) s += ev_tbl[8*i + int'(p[3*i +: 3])];
        return s;
    endfunction

    task automatic rom_fill(input int mode);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                case (mode)
                    0:       rom[8*w+j] = 8*w + j;
                    1:       rom[8*w+j] = (w == j) ? 1 : int'($urandom_range(127, 10));
                    default: rom[8*w+j] = 5;
                endcase
            end
        end
    endtask

    task automatic model_reset();
        res_q.delete();
        n_acc = 0; n_res = 0; exp_min = 1023; exp_cnt = 0;
        load_k = 0; load_bad = 0; seq_bad = 0; prev_key = 0; have_prev = 1'b0;
        for (int i = 0; i < 64; i++) ev_tbl[i] = 0;
    endtask

    // Runs at the falling edge: observes DUT, then drives ready/result for the next edge.
    task automatic monitor();
        longint key;
        int     c;
        if (RST) begin
            perm_ready = 1'b0;
            res_valid  = 1'b0;
            return;
        end
        if (tbl_we) begin
            if (load_k >= 64 || {tbl_w, tbl_j} != 6'(load_k) || int'(tbl_data) != rom[load_k]) load_bad++;
            ev_tbl[{tbl_w, tbl_j}] = int'(tbl_data);
            load_k++;
        end
        case (ready_mode)
            0:       perm_ready = 1'b0;
            1:       perm_ready = 1'b1;
            default: perm_ready = (n_acc >= 3000) || ($urandom_range(3, 0) != 0);
        endcase
        if (perm_valid && perm_ready) begin
            key = lex_key(perm);
            if (!is_perm(perm) || (have_prev && key <= prev_key)) seq_bad++;
            prev_key  = key;
            have_prev = 1'b1;
            res_q.push_back(perm_cost(perm));
            n_acc++;
        end
        res_valid = 1'b0;
        res_cost  = '0;
        if (res_q.size() > 0 && (pop_mode == 0 || n_acc >= 3000 || $urandom_range(3, 0) != 0)) begin
            c = res_q.pop_front();
            res_valid = 1'b1;
            res_cost  = SUM_W'(c);
            n_res++;
            if (c < exp_min) begin
                exp_min = c;
                exp_cnt = 1;
            end else if (c == exp_min && exp_cnt < 15) begin
                exp_cnt++;
            end
        end else if (noise_en && (Valid || (!perm_valid && n_acc == 0)) && $urandom_range(1, 0) == 1) begin
            res_valid = 1'b1;
            res_cost  = '0;
        end
    endtask

    task automatic tick();
        rom_addr = {W, J};
        @(posedge CLK);
        #1 Cost = COST_W'(rom[rom_addr]);
        @(negedge CLK);
        monitor();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_W"},          W,          0);
        check({tag, "_J"},          J,          0);
        check({tag, "_tbl_we"},     tbl_we,     0);
        check({tag, "_tbl_wj"},     {tbl_w, tbl_j}, 0);
        check({tag, "_tbl_data"},   tbl_data,   0);
        check({tag, "_perm_valid"}, perm_valid, 0);
        check({tag, "_perm"},       perm,       pk(0, 1, 2, 3, 4, 5, 6, 7));
        check({tag, "_MinCost"},    MinCost,    1023);
        check({tag, "_MatchCount"}, MatchCount, 0);
        check({tag, "_Valid"},      Valid,      0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!Valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, Valid, 1);
    endtask

    initial begin
        int n;
        model_reset();
        ready_mode = 0; pop_mode = 0; noise_en = 1'b0;
        rom_fill(0);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset("por");

        RST = 1'b0;
        model_reset();
        repeat (20) tick();
        check("load_addr_20", {W, J}, 20);
        RST = 1'b1;
        #1 check_reset("mid_load");
        tick(); tick();
        RST = 1'b0;
        model_reset();

        n = 0;
        while (!perm_valid && n < 200) begin
            tick();
            n++;
        end
        check("run_entry_cycle", n, 65);
        check("load_pulses", load_k, 64);
        check("load_bad", load_bad, 0);

        repeat (5) tick();
        check("hold_valid", perm_valid, 1);
        check("hold_perm", perm, pk(0, 1, 2, 3, 4, 5, 6, 7));
        ready_mode = 1;
        tick(); tick();
        check("succ_first", perm, pk(0, 1, 2, 3, 4, 5, 7, 6));
        n = 0;
        while (perm != pk(0, 1, 2, 3, 4, 7, 6, 5) && n < 100) begin
            tick();
            n++;
        end
        check("reach_47654", perm, pk(0, 1, 2, 3, 4, 7, 6, 5));
        tick();
        check("succ_54467", perm, pk(0, 1, 2, 3, 5, 4, 6, 7));

        n = 0;
        while (n_acc < 1000 && n < 5000) begin
            tick();
            n++;
        end
        check("acc_1000", n_acc, 1000);
        check("seq_pre_reset", seq_bad, 0);
        perm_ready = 1'b0;
        res_valid  = 1'b0;
        RST        = 1'b1;
        #1 check_reset("mid_run");
        tick(); tick();

        // Diagonal 1, random off-diagonal >= 10: identity is the unique minimum.
        rom_fill(1);
        RST = 1'b0;
        model_reset();
        ready_mode = 2; pop_mode = 1; noise_en = 1'b1;
        wait_valid("run2", 60000);
        check("run2_drain_empty", res_q.size(), 0);
        check("run2_accepts", n_acc, NPERM);
        check("run2_results", n_res, NPERM);
        check("run2_seq", seq_bad, 0);
        check("run2_load_bad", load_bad, 0);
        check("run2_min_model", MinCost, exp_min);
        check("run2_cnt_model", MatchCount, exp_cnt);
        check("run2_min", MinCost, 8);
        check("run2_cnt", MatchCount, 1);
        check("run2_pv_off", perm_valid, 0);
        repeat (10) tick();
        check("run2_min_frozen", MinCost, 8);
        check("run2_cnt_frozen", MatchCount, 1);
        check("run2_valid_hold", Valid, 1);
        check("run2_no_extra_acc", n_acc, NPERM);

        perm_ready = 1'b0;
        res_valid  = 1'b0;
        RST        = 1'b1;
        #1 check_reset("post_done");
        tick(); tick();

        rom_fill(2);
        RST = 1'b0;
        model_reset();
        ready_mode = 1; pop_mode = 0; noise_en = 1'b0;
        wait_valid("run3", 50000);
        check("run3_accepts", n_acc, NPERM);
        check("run3_seq", seq_bad, 0);
        check("run3_min_model", MinCost, exp_min);
        check("run3_min", MinCost, 40);
        check("run3_cnt_sat", MatchCount, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
